cpu_mem_responder: RTL

//  Memory-side responder for the accumulator CPU's 32x8 main memory. Serves one

---
 rtl/cpu_mem_responder.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/cpu_mem_responder.sv
// cpu_mem_responder
//   Memory-side responder for the accumulator CPU's main memory (DEPTH = 2**AW words
//   of DW bits). Serves one outstanding request at a time over valid/ready, including
//   indirect accesses where the effective address is fetched from the array first.
//
// Ports
//   clk_i        rising-edge clock
//   rst_i        synchronous, active-high reset
//   req_valid_i  request present
//   req_ready_o  responder can accept a request this cycle (IDLE only)
//   req_we_i     1 = write, 0 = read
//   req_ind_i    1 = indirect: effective address = mem[req_addr_i][AW-1:0]
//   req_addr_i   address operand
//   req_wdata_i  write data
//   rsp_valid_o  response present, held until rsp_ready_i
//   rsp_ready_i  initiator accepts response
//   rsp_data_o   read data, or the written data echoed as a write ack
//
// Configuration
//   CPU_MEM_INIT_EN defined: reset enters an init sweep that writes
//     mem[i] = i + INIT_OFFSET, one word per cycle, before the first request.
//   CPU_MEM_INIT_EN undefined: reset goes straight to IDLE; array is not initialised.

module cpu_mem_responder #(
    parameter int unsigned AW          = 5,
    parameter int unsigned DW          = 8,
    parameter int unsigned INIT_OFFSET = 3
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          req_valid_i,
    output logic          req_ready_o,
    input  logic          req_we_i,
    input  logic          req_ind_i,
    input  logic [AW-1:0] req_addr_i,
    input  logic [DW-1:0] req_wdata_i,
    output logic          rsp_valid_o,
    input  logic          rsp_ready_i,
    output logic [DW-1:0] rsp_data_o
);

    localparam int unsigned Depth = 2 ** AW;

`ifdef CPU_MEM_INIT_EN
    localparam logic [2:0] StInit = 3'd0;
`endif
    localparam logic [2:0] StIdle = 3'd1;
    localparam logic [2:0] StPtr  = 3'd2;
    localparam logic [2:0] StAcc  = 3'd3;
    localparam logic [2:0] StRsp  = 3'd4;

`ifdef CPU_MEM_INIT_EN
    localparam logic [2:0] ResetState = StInit;
`else
    localparam logic [2:0] ResetState = StIdle;
`endif

    logic [2:0]    state_q, state_d;
    logic          we_q, we_d;
    logic [DW-1:0] wdata_q, wdata_d;
    // Holds the address operand on accept, then the dereferenced pointer after PTR,
    // so no separate operand register is needed.
    logic [AW-1:0] ea_q, ea_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [DW-1:0] rsp_data_q, rsp_data_d;

`ifdef CPU_MEM_INIT_EN
    logic [AW-1:0] cnt_q, cnt_d;
`endif

    logic [DW-1:0] mem_q [Depth];
    logic [DW-1:0] rd_word;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [DW-1:0] mem_wdata;

    assign rd_word = mem_q[ea_q];

    // Forced low while reset is asserted so nothing is accepted across a reset edge.
    assign req_ready_o = (state_q == StIdle) && !rst_i;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_data_o  = rsp_data_q;

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        wdata_d     = wdata_q;
        ea_d        = ea_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        mem_we      = 1'b0;
        mem_waddr   = ea_q;
        mem_wdata   = wdata_q;
`ifdef CPU_MEM_INIT_EN
        cnt_d       = cnt_q;
`endif

        unique case (state_q)
`ifdef CPU_MEM_INIT_EN
            StInit: begin
                mem_we    = 1'b1;
                mem_waddr = cnt_q;
                mem_wdata = DW'(cnt_q) + DW'(INIT_OFFSET);
                cnt_d     = cnt_q + AW'(1);
                if (cnt_q == AW'(Depth - 1)) begin
                    state_d = StIdle;
                end
            end
`endif
            StIdle: begin
                if (req_valid_i) begin
                    we_d    = req_we_i;
                    wdata_d = req_wdata_i;
                    ea_d    = req_addr_i;
                    state_d = req_ind_i ? StPtr : StAcc;
                end
            end
            StPtr: begin
                // Upper DW-AW pointer bits are dropped, so pointers wrap in the array.
                ea_d    = rd_word[AW-1:0];
                state_d = StAcc;
            end
            StAcc: begin
                rsp_valid_d = 1'b1;
                state_d     = StRsp;
                if (we_q) begin
                    mem_we     = 1'b1;
                    rsp_data_d = wdata_q;
                end else begin
                    rsp_data_d = rd_word;
                end
            end
            StRsp: begin
                if (rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ResetState;
            we_q        <= 1'b0;
            wdata_q     <= '0;
            ea_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            wdata_q     <= wdata_d;
            ea_q        <= ea_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

`ifdef CPU_MEM_INIT_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    // Array has no reset; a write pending at a reset edge is discarded.
    always_ff @(posedge clk_i) begin
        if (mem_we && !rst_i) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

endmodule
